mul16_seq: RTL and testbench

Sequential 16-bit multiplier controller for the Hack datapath. It time-shares a single `Add16` ripple adder across up to 16 shift-and-add iterations to produce the low 16 bits of `a*b`. Operands arrive on a valid/ready request channel and the product leaves on a valid/ready response channel. The block sits beside the ALU as a multi-cycle extension unit and adds exactly one 16-bit adder to the design.

---
 rtl/hack_pkg.sv | 24 ++
 rtl/mul16_seq_if.sv | 24 ++
 rtl/mul16_seq_add16.sv | 22 ++
 rtl/mul16_seq.sv | 91 +++++++++
 tb/tb_mul16_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared Hack datapath types: word width and the
// multiplier controller state encoding.
package hack_pkg;

  localparam int HACK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // 2'd3 is unreachable; fold it onto IDLE
  function automatic mul_state_t decode_state(
    input logic [1:0] s
  );
    mul_state_t d;
    d = IDLE;
    if (s == 2'd1) d = RUN;
    if (s == 2'd2) d = DONE;
    return d;
  endfunction

endpackage

// File: rtl/mul16_seq_if.sv
// Request/response handshake bundle for the
// sequential multiplier.
interface mul16_seq_if;

  logic                        req_valid;
  logic                        req_ready;
  logic [hack_pkg::HACK_W-1:0] req_a;
  logic [hack_pkg::HACK_W-1:0] req_b;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [hack_pkg::HACK_W-1:0] product;
  logic                        busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, product, busy
  );

endinterface

// File: rtl/mul16_seq_add16.sv
// Hack Add16: 16-bit ripple-carry adder, carry-out
// dropped so sums wrap modulo 2^16.
module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  logic [15:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_sum
    assign out[i] = a[i] ^ b[i] ^ c[i];
  end

  for (genvar i = 0; i < 15; i++) begin : g_cy
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

endmodule

// File: rtl/mul16_seq.sv
// Shift-and-add multiplier sharing one Add16;
// returns the low 16 bits of a*b.
module mul16_seq
  import hack_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  mul16_seq_if.slave  bus
);

  logic [1:0]        state_q;
  mul_state_t        st;
  mul_state_t        st_d;
  logic [HACK_W-1:0] acc_q, acc_d;
  logic [HACK_W-1:0] mcand_q, mcand_d;
  logic [HACK_W-1:0] mplier_q, mplier_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [HACK_W-1:0] sum;
  logic              is_idle, is_run, is_done;
  logic              last;

  assign st      = decode_state(state_q);
  assign is_idle = (st == IDLE);
  assign is_run  = (st == RUN);
  assign is_done = (st == DONE);

  Add16 u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .out (sum)
  );

  // stop once the remaining multiplier bits are gone
  assign last = (cnt_q == 4'd15)
              | (EARLY_EXIT
                 & (mplier_q[HACK_W-1:1] == '0));

  always_comb begin
    st_d     = st;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      is_idle: begin
        if (bus.req_valid) begin
          acc_d    = '0;
          mcand_d  = bus.req_a;
          mplier_d = bus.req_b;
          cnt_d    = '0;
          st_d     = RUN;
        end
      end
      is_run: begin
        if (mplier_q[0]) acc_d = sum;
        mcand_d  = {mcand_q[HACK_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[HACK_W-1:1]};
        cnt_d    = cnt_q + 4'd1;
        if (last) st_d = DONE;
      end
      is_done: begin
        if (bus.resp_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= st_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready  = is_idle;
  assign bus.resp_valid = is_done;
  assign bus.busy       = !is_idle;
  assign bus.product    = acc_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq with and without
// early exit, scoreboard-checked.
module tb_mul16_seq;

  typedef struct {
    logic [15:0] prod;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v1 = 1'b0;
  logic        v0 = 1'b0;
  logic        rr = 1'b0;
  logic [15:0] ra = '0;
  logic [15:0] rb = '0;
  int          checks = 0;
  int          fails = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  mul16_seq_if i1 ();
  mul16_seq_if i0 ();

  assign i1.req_valid  = v1;
  assign i1.req_a      = ra;
  assign i1.req_b      = rb;
  assign i1.resp_ready = rr;
  assign i0.req_valid  = v0;
  assign i0.req_a      = ra;
  assign i0.req_b      = rb;
  assign i0.resp_ready = rr;

  mul16_seq #(.EARLY_EXIT(1'b1)) u_e1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i1.slave)
  );

  mul16_seq #(.EARLY_EXIT(1'b0)) u_e0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i0.slave)
  );

  function automatic logic [15:0] prod(input bit ee);
    return ee ? i1.product : i0.product;
  endfunction

  function automatic logic rvld(input bit ee);
    return ee ? i1.resp_valid : i0.resp_valid;
  endfunction

  function automatic logic rdy(input bit ee);
    return ee ? i1.req_ready : i0.req_ready;
  endfunction

  function automatic logic bsy(input bit ee);
    return ee ? i1.busy : i0.busy;
  endfunction

  function automatic int model_n(
    input bit ee, input logic [15:0] b
  );
    if (!ee) return 16;
    for (int i = 15; i >= 0; i--)
      if (b[i]) return i + 1;
    return 1;
  endfunction

  task automatic setv(input bit ee, input logic v);
    if (ee) v1 = v;
    else    v0 = v;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic op(
    input bit          ee,
    input logic [15:0] a,
    input logic [15:0] b,
    input int          hold,
    input bit          pulse
  );
    exp_t        e;
    int          cyc;
    int          bcnt;
    bit          got;
    bit          stable;
    logic [15:0] p;
    ra = a;
    rb = b;
    setv(ee, 1'b1);
    @(posedge clk); #1;
    setv(ee, 1'b0);
    e.prod = a * b;
    e.n    = model_n(ee, b);
    sb.push_back(e);
    bcnt = bsy(ee) ? 1 : 0;
    if (pulse) begin
      ra = 16'hBEEF;
      rb = 16'h00FF;
      setv(ee, 1'b1);
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      setv(ee, 1'b0);
      if (bsy(ee)) bcnt++;
      got = rvld(ee);
    end
    chk("resp_timeout", 32'(got), 32'd1);
    e = sb.pop_front();
    chk("product", 32'(prod(ee)), 32'(e.prod));
    chk("latency", 32'(cyc), 32'(e.n));
    p = prod(ee);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bsy(ee)) bcnt++;
      if (prod(ee) !== p || rvld(ee) !== 1'b1
          || rdy(ee) !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0)
      chk("hold_stable", 32'(stable), 32'd1);
    rr = 1'b1;
    if (hold > 0) begin
      ra = 16'h0F0F;
      rb = 16'h0003;
      setv(ee, 1'b1);
    end
    @(posedge clk); #1;
    rr = 1'b0;
    setv(ee, 1'b0);
    chk("idle_ready", 32'(rdy(ee)), 32'd1);
    chk("idle_busy", 32'(bsy(ee)), 32'd0);
    if (hold > 0)
      chk("no_accept_prod", 32'(prod(ee)), 32'(p));
    chk("busy_cycles", 32'(bcnt),
        32'(e.n + 1 + hold));
  endtask

  initial begin
    #7;
    chk("rst_prod1", 32'(i1.product), 32'd0);
    chk("rst_prod0", 32'(i0.product), 32'd0);
    chk("rst_ready", 32'(i1.req_ready), 32'd1);
    chk("rst_rvld", 32'(i1.resp_valid), 32'd0);
    chk("rst_busy", 32'(i1.busy), 32'd0);
    #5;
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(1'b1, 16'd3, 16'd5, 0, 1'b0);
    op(1'b1, 16'h00FF, 16'h0101, 0, 1'b0);
    op(1'b0, 16'h00FF, 16'h0101, 0, 1'b0);
    op(1'b1, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    op(1'b1, 16'h8000, 16'd2, 0, 1'b0);
    op(1'b1, 16'h1234, 16'd0, 0, 1'b1);
    op(1'b1, 16'h0003, 16'h0050, 0, 1'b1);
    op(1'b0, 16'h1357, 16'h0246, 0, 1'b1);
    op(1'b1, 16'h1357, 16'h0246, 5, 1'b0);
    op(1'b1, 16'h00A5, 16'h0003, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 16'($urandom), 16'($urandom), 0, 1'b0);
      op(1'b0, 16'($urandom), 16'($urandom), 0, 1'b0);
    end

    ra = 16'd7;
    rb = 16'h00F0;
    setv(1'b1, 1'b1);
    @(posedge clk); #1;
    setv(1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_prod", 32'(i1.product), 32'd0);
    chk("mid_rst_busy", 32'(i1.busy), 32'd0);
    chk("mid_rst_ready", 32'(i1.req_ready), 32'd1);
    chk("mid_rst_rvld", 32'(i1.resp_valid), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i1.resp_valid !== 1'b0)
        chk("ghost_resp", 32'(i1.resp_valid), 32'd0);
    end
    op(1'b1, 16'd9, 16'd9, 0, 1'b0);
    chk("final_81", 32'(i1.product), 32'h51);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
